// File: rtl/softmax_rdma_pkg.sv
// Shared width constants for the Softmax read-DMA front end.
package softmax_rdma_pkg;
  localparam int TOUT_DEF           = 8;
  localparam int MAX_DAT_DW         = 8;
  localparam int LOG2_AXI_BURST_LEN = 2;
  localparam int LOG2_W             = 8;
  localparam int LOG2_H             = 8;
  localparam int LOG2_SOFTMAX_PIXEL = 16;
  localparam int LOG2_CH            = 8;
  localparam int LOG2_TOUT          = 3;
  localparam int CG_W               = LOG2_CH - LOG2_TOUT;
  localparam int PIXEL_DATA_BYTES   = TOUT_DEF * MAX_DAT_DW / 8;
endpackage

// File: rtl/softmax_rdma_fifo.sv
// Synchronous first-word-fall-through FIFO with registered pointers.
// Latency: a pushed word is visible on dout the next cycle.
// Backpressure: none; push while full is only honoured together with a pop.
module softmax_rdma_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            din,
  input  logic                     pop,
  output logic [DW-1:0]            dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0] ONE_C   = 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE_C;
      if (do_pop)  rd_ptr <= rd_ptr + ONE_C;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= DEPTH_C);
endmodule

// File: rtl/softmax_rdma.sv
// Softmax read DMA: walks h/w-burst/ch-group loops, issues credit-gated MCIF reads, streams beats out.
// Latency: first command the cycle after start; a returned beat is offered downstream the next cycle.
// Backpressure: dat_out_rdy low fills the FIFO, which starves credit and stalls command issue.
module softmax_rdma
  import softmax_rdma_pkg::*;
#(
  parameter int TOUT       = TOUT_DEF,
  parameter int DW         = MAX_DAT_DW,
  parameter int BL_W       = LOG2_AXI_BURST_LEN,
  parameter int FIFO_DEPTH = 2 * (1 << BL_W)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [LOG2_W-1:0]             w,
  input  logic [LOG2_H-1:0]             h,
  input  logic [LOG2_SOFTMAX_PIXEL-1:0] pixel_in,
  input  logic [CG_W-1:0]               ch_div_Tout,
  input  logic [31:0]                   feature_base_addr,
  input  logic [25:0]                   feature_surface_stride,
  input  logic [15:0]                   feature_line_stride,
  output logic                          rdma_done,
  output logic                          Softmax2mcif_rd_req_vld,
  input  logic                          Softmax2mcif_rd_req_rdy,
  output logic [BL_W+31:0]              Softmax2mcif_rd_req_pd,
  input  logic                          mcif2Softmax_rd_resp_vld,
  input  logic [TOUT*DW-1:0]            mcif2Softmax_rd_resp_pd,
  output logic                          dat_out_vld,
  input  logic                          dat_out_rdy,
  output logic [TOUT*DW-1:0]            dat_out_pd,
  output logic                          dat_out_pad
);
  localparam int BL          = 1 << BL_W;
  localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1;
  localparam int BURST_BYTES = BL * (TOUT * DW / 8);
  localparam logic [CNT_W-1:0]  CNT_ONE   = 1;
  localparam logic [CNT_W-1:0]  DEPTH_C   = FIFO_DEPTH[CNT_W-1:0];
  localparam logic [BL_W-1:0]   BL_ONE    = 1;
  localparam logic [BL_W-1:0]   BL_MAX    = '1;
  localparam logic [LOG2_W-1:0] W_ONE     = 1;
  localparam logic [LOG2_H-1:0] H_ONE     = 1;
  localparam logic [CG_W-1:0]   CG_ONE    = 1;

  logic               working, busy_o;
  logic [CG_W-1:0]    ch_cnt;
  logic [LOG2_W-1:0]  wb_cnt;
  logic [LOG2_H-1:0]  h_cnt;
  logic [31:0]        surf_bias, wb_bias, line_bias;
  logic [CNT_W-1:0]   outstanding, fifo_count, credit, need;
  logic [LOG2_W-1:0]  wb_last;
  logic [BL_W-1:0]    w_tail, cmd_len;
  logic [31:0]        cmd_addr;
  logic               ch_last, wb_is_last, h_last, last_cmd, hs, start_ok;
  logic               fifo_full, fifo_empty, pop, final_pop;
  logic [TOUT*DW-1:0] fifo_dout;

  assign start_ok   = start && !working && !busy_o;
  assign wb_last    = (w - W_ONE) >> BL_W;
  assign w_tail     = w[BL_W-1:0] - BL_ONE;
  assign ch_last    = (ch_cnt == ch_div_Tout - CG_ONE);
  assign wb_is_last = (wb_cnt == wb_last);
  assign h_last     = (h_cnt == h - H_ONE);
  assign last_cmd   = ch_last && wb_is_last && h_last;
  // A w-multiple of BL makes the tail length wrap to BL-1, i.e. a full burst.
  assign cmd_len    = wb_is_last ? w_tail : BL_MAX;
  assign need       = CNT_W'(cmd_len) + CNT_ONE;
  assign credit     = DEPTH_C - fifo_count - outstanding;
  assign cmd_addr   = feature_base_addr + line_bias + wb_bias + surf_bias;

  assign Softmax2mcif_rd_req_vld = working && (credit >= need);
  assign Softmax2mcif_rd_req_pd  = Softmax2mcif_rd_req_vld ? {cmd_len, cmd_addr} : '0;
  assign hs = Softmax2mcif_rd_req_vld && Softmax2mcif_rd_req_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      working   <= 1'b0;
      ch_cnt    <= '0;
      wb_cnt    <= '0;
      h_cnt     <= '0;
      surf_bias <= '0;
      wb_bias   <= '0;
      line_bias <= '0;
    end else if (start_ok) begin
      working   <= 1'b1;
      ch_cnt    <= '0;
      wb_cnt    <= '0;
      h_cnt     <= '0;
      surf_bias <= '0;
      wb_bias   <= '0;
      line_bias <= '0;
    end else if (hs) begin
      if (!ch_last) begin
        ch_cnt    <= ch_cnt + CG_ONE;
        surf_bias <= surf_bias + 32'(feature_surface_stride);
      end else begin
        ch_cnt    <= '0;
        surf_bias <= '0;
        if (!wb_is_last) begin
          wb_cnt  <= wb_cnt + W_ONE;
          wb_bias <= wb_bias + 32'(BURST_BYTES);
        end else begin
          wb_cnt    <= '0;
          wb_bias   <= '0;
          h_cnt     <= h_last ? '0 : h_cnt + H_ONE;
          line_bias <= h_last ? '0 : line_bias + 32'(feature_line_stride);
        end
      end
      if (last_cmd) working <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) outstanding <= '0;
    else        outstanding <= outstanding + (hs ? need : '0)
                               - (mcif2Softmax_rd_resp_vld ? CNT_ONE : '0);
  end

  softmax_rdma_fifo #(.DW(TOUT*DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (mcif2Softmax_rd_resp_vld),
    .din   (mcif2Softmax_rd_resp_pd),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  a_no_drop: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_full && mcif2Softmax_rd_resp_vld && !pop));

  // Output-side loop mirrors the issue order with the burst beat innermost.
  logic [BL_W-1:0]   beat_cnt_o, beat_max_o;
  logic [CG_W-1:0]   ch_cnt_o;
  logic [LOG2_W-1:0] wb_cnt_o;
  logic [LOG2_H-1:0] h_cnt_o;
  logic [31:0]       row_base_o, current_pixel;
  logic              beat_last_o, ch_last_o, wb_last_o, h_last_o;

  assign dat_out_vld   = !fifo_empty;
  assign dat_out_pd    = dat_out_vld ? fifo_dout : '0;
  assign pop           = dat_out_vld && dat_out_rdy;
  assign wb_last_o     = (wb_cnt_o == wb_last);
  assign beat_max_o    = wb_last_o ? w_tail : BL_MAX;
  assign beat_last_o   = (beat_cnt_o == beat_max_o);
  assign ch_last_o     = (ch_cnt_o == ch_div_Tout - CG_ONE);
  assign h_last_o      = (h_cnt_o == h - H_ONE);
  assign current_pixel = row_base_o + 32'({wb_cnt_o, {BL_W{1'b0}}}) + 32'(beat_cnt_o);
  assign dat_out_pad   = dat_out_vld && (current_pixel >= 32'(pixel_in));
  assign final_pop     = pop && beat_last_o && ch_last_o && wb_last_o && h_last_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_o     <= 1'b0;
      rdma_done  <= 1'b0;
      beat_cnt_o <= '0;
      ch_cnt_o   <= '0;
      wb_cnt_o   <= '0;
      h_cnt_o    <= '0;
      row_base_o <= '0;
    end else begin
      rdma_done <= final_pop;
      if (start_ok) begin
        busy_o     <= 1'b1;
        beat_cnt_o <= '0;
        ch_cnt_o   <= '0;
        wb_cnt_o   <= '0;
        h_cnt_o    <= '0;
        row_base_o <= '0;
      end else if (pop) begin
        if (final_pop) busy_o <= 1'b0;
        if (!beat_last_o) begin
          beat_cnt_o <= beat_cnt_o + BL_ONE;
        end else begin
          beat_cnt_o <= '0;
          if (!ch_last_o) begin
            ch_cnt_o <= ch_cnt_o + CG_ONE;
          end else begin
            ch_cnt_o <= '0;
            if (!wb_last_o) begin
              wb_cnt_o <= wb_cnt_o + W_ONE;
            end else begin
              wb_cnt_o   <= '0;
              h_cnt_o    <= h_last_o ? '0 : h_cnt_o + H_ONE;
              row_base_o <= h_last_o ? '0 : row_base_o + 32'(w);
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_softmax_rdma.sv
// Directed bench for softmax_rdma with a 1-cycle-latency MCIF model and output logger.
module tb_softmax_rdma;
  import softmax_rdma_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  w, h;
  logic [15:0] pixel_in;
  logic [4:0]  ch_div_Tout;
  logic [31:0] base;
  logic [25:0] sstride;
  logic [15:0] lstride;
  logic        rdma_done;
  logic        req_vld, req_rdy;
  logic [33:0] req_pd;
  logic        resp_vld;
  logic [63:0] resp_pd;
  logic        dat_out_vld, dat_out_rdy, dat_out_pad;
  logic [63:0] dat_out_pd;

  softmax_rdma dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .start                    (start),
    .w                        (w),
    .h                        (h),
    .pixel_in                 (pixel_in),
    .ch_div_Tout              (ch_div_Tout),
    .feature_base_addr        (base),
    .feature_surface_stride   (sstride),
    .feature_line_stride      (lstride),
    .rdma_done                (rdma_done),
    .Softmax2mcif_rd_req_vld  (req_vld),
    .Softmax2mcif_rd_req_rdy  (req_rdy),
    .Softmax2mcif_rd_req_pd   (req_pd),
    .mcif2Softmax_rd_resp_vld (resp_vld),
    .mcif2Softmax_rd_resp_pd  (resp_pd),
    .dat_out_vld              (dat_out_vld),
    .dat_out_rdy              (dat_out_rdy),
    .dat_out_pd               (dat_out_pd),
    .dat_out_pad              (dat_out_pad)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [31:0] cmd_addr_q[$];
  int          cmd_len_q[$];
  logic [63:0] pend_q[$];
  logic [63:0] out_q[$];
  bit          pad_q[$];
  int req_beats, done_cnt, done_obs, last_pop_obs, first_req_obs, start_obs;

  // MCIF model: commands accepted at a clock edge return one beat per cycle from the next edge on.
  initial begin : mcif_model
    resp_vld = 1'b0;
    resp_pd  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        pend_q.delete();
        resp_vld = 1'b0;
        resp_pd  = '0;
      end else begin
        if (pend_q.size() > 0) begin
          resp_vld = 1'b1;
          resp_pd  = pend_q.pop_front();
        end else begin
          resp_vld = 1'b0;
          resp_pd  = '0;
        end
        if (req_vld && first_req_obs < 0) first_req_obs = cyc;
        if (req_vld && req_rdy) begin
          cmd_addr_q.push_back(req_pd[31:0]);
          cmd_len_q.push_back(int'(req_pd[33:32]));
          req_beats += int'(req_pd[33:32]) + 1;
          for (int b = 0; b <= int'(req_pd[33:32]); b++)
            pend_q.push_back({req_pd[31:0], 32'(b)});
        end
        if (dat_out_vld && dat_out_rdy) begin
          out_q.push_back(dat_out_pd);
          pad_q.push_back(dat_out_pad);
          last_pop_obs = cyc;
        end
        if (rdma_done) begin
          done_cnt++;
          done_obs = cyc;
        end
      end
    end
  end

  task automatic clear_logs();
    cmd_addr_q.delete();
    cmd_len_q.delete();
    out_q.delete();
    pad_q.delete();
    req_beats = 0;
    done_cnt = 0;
    done_obs = -1;
    last_pop_obs = -1;
    first_req_obs = -1;
  endtask

  task automatic configure(input logic [31:0] b, input logic [25:0] ss, input logic [15:0] ls,
                           input int wv, input int hv, input int cv, input int pin);
    base = b; sstride = ss; lstride = ls;
    w = 8'(wv); h = 8'(hv); ch_div_Tout = 5'(cv); pixel_in = 16'(pin);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    start_obs = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (req_vld !== 1'b0) begin failures++; $display("FAIL rst_req_vld: got %b want 0", req_vld); end
    checks++; if (req_pd !== '0) begin failures++; $display("FAIL rst_req_pd: got %h want 0", req_pd); end
    checks++; if (dat_out_vld !== 1'b0) begin failures++; $display("FAIL rst_dat_vld: got %b want 0", dat_out_vld); end
    checks++; if (rdma_done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b want 0", rdma_done); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (req_vld !== 1'b0) begin failures++; $display("FAIL idle_req_vld: got %b want 0", req_vld); end
  endtask

  task automatic test_single();
    bit ok;
    clear_logs();
    configure(32'h2000, 26'h100, 16'h0, 4, 1, 1, 100);
    pulse_start();
    wait_done(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout: done seen %0d want 1", done_cnt); end
    checks++; if (first_req_obs !== start_obs + 1) begin failures++; $display("FAIL single_first_req: got cycle %0d want %0d", first_req_obs, start_obs + 1); end
    checks++; if (cmd_addr_q.size() !== 1) begin failures++; $display("FAIL single_cmd_count: got %0d want 1", cmd_addr_q.size()); end
    if (cmd_addr_q.size() > 0) begin
      checks++; if (cmd_addr_q[0] !== 32'h2000 || cmd_len_q[0] !== 3) begin failures++; $display("FAIL single_cmd: got %h/%0d want 2000/3", cmd_addr_q[0], cmd_len_q[0]); end
    end
    checks++; if (out_q.size() !== 4) begin failures++; $display("FAIL single_beats: got %0d want 4", out_q.size()); end
    for (int i = 0; i < out_q.size() && i < 4; i++) begin
      checks++; if (out_q[i] !== {32'h2000, 32'(i)} || pad_q[i] !== 1'b0) begin failures++; $display("FAIL single_beat%0d: got %h pad %b want %h pad 0", i, out_q[i], pad_q[i], {32'h2000, 32'(i)}); end
    end
    checks++; if (done_obs !== last_pop_obs + 1) begin failures++; $display("FAIL single_done_timing: got cycle %0d want %0d", done_obs, last_pop_obs + 1); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL single_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_addr();
    bit ok;
    logic [31:0] ea [8];
    int el [8];
    int idx;
    ea = '{32'h1000, 32'h11000, 32'h1020, 32'h11020, 32'h1400, 32'h11400, 32'h1420, 32'h11420};
    el = '{3, 3, 2, 2, 3, 3, 2, 2};
    clear_logs();
    configure(32'h1000, 26'h10000, 16'h400, 7, 2, 2, 1000);
    pulse_start();
    wait_done(400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL addr_timeout: done seen %0d want 1", done_cnt); end
    checks++; if (cmd_addr_q.size() !== 8) begin failures++; $display("FAIL addr_cmd_count: got %0d want 8", cmd_addr_q.size()); end
    for (int i = 0; i < 8 && i < cmd_addr_q.size(); i++) begin
      checks++; if (cmd_addr_q[i] !== ea[i] || cmd_len_q[i] !== el[i]) begin failures++; $display("FAIL addr_cmd%0d: got %h/%0d want %h/%0d", i, cmd_addr_q[i], cmd_len_q[i], ea[i], el[i]); end
    end
    checks++; if (out_q.size() !== 28) begin failures++; $display("FAIL addr_beats: got %0d want 28", out_q.size()); end
    idx = 0;
    for (int i = 0; i < 8; i++)
      for (int b = 0; b <= el[i]; b++) begin
        if (idx < out_q.size()) begin
          checks++; if (out_q[idx] !== {ea[i], 32'(b)} || pad_q[idx] !== 1'b0) begin failures++; $display("FAIL addr_beat%0d: got %h pad %b want %h pad 0", idx, out_q[idx], pad_q[idx], {ea[i], 32'(b)}); end
        end
        idx++;
      end
  endtask

  task automatic test_backpressure();
    bit ok;
    int idx;
    clear_logs();
    configure(32'h4000, 26'h100, 16'h0, 16, 1, 4, 1000);
    dat_out_rdy = 1'b0;
    pulse_start();
    repeat (40) @(negedge clk);
    checks++; if (req_beats !== 8) begin failures++; $display("FAIL bp_req_beats: got %0d want 8", req_beats); end
    checks++; if (cmd_addr_q.size() !== 2) begin failures++; $display("FAIL bp_cmd_count: got %0d want 2", cmd_addr_q.size()); end
    #1;
    checks++; if (req_vld !== 1'b0) begin failures++; $display("FAIL bp_stalled: got req_vld %b want 0", req_vld); end
    checks++; if (dat_out_vld !== 1'b1) begin failures++; $display("FAIL bp_dat_vld: got %b want 1", dat_out_vld); end
    pulse_start();
    @(negedge clk);
    dat_out_rdy = 1'b1;
    wait_done(600, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_timeout: done seen %0d want 1", done_cnt); end
    checks++; if (cmd_addr_q.size() !== 16) begin failures++; $display("FAIL restart_ignored_cmds: got %0d want 16", cmd_addr_q.size()); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
    checks++; if (out_q.size() !== 64) begin failures++; $display("FAIL bp_beats: got %0d want 64", out_q.size()); end
    idx = 0;
    for (int wb = 0; wb < 4; wb++)
      for (int c = 0; c < 4; c++)
        for (int b = 0; b < 4; b++) begin
          if (idx < out_q.size()) begin
            checks++; if (out_q[idx] !== {32'h4000 + 32'(wb * 32 + c * 256), 32'(b)}) begin failures++; $display("FAIL bp_beat%0d: got %h want %h", idx, out_q[idx], {32'h4000 + 32'(wb * 32 + c * 256), 32'(b)}); end
          end
          idx++;
        end
  endtask

  task automatic test_pad();
    bit ok;
    clear_logs();
    configure(32'h0, 26'h0, 16'h0, 8, 1, 1, 5);
    pulse_start();
    wait_done(200, ok);
    checks++; if (!ok || out_q.size() !== 8) begin failures++; $display("FAIL pad8_beats: got %0d want 8", out_q.size()); end
    for (int i = 0; i < out_q.size(); i++) begin
      checks++; if (pad_q[i] !== (i >= 5)) begin failures++; $display("FAIL pad8_beat%0d: got %b want %b", i, pad_q[i], i >= 5); end
    end
    clear_logs();
    configure(32'h0, 26'h0, 16'h40, 7, 2, 1, 10);
    pulse_start();
    wait_done(200, ok);
    checks++; if (!ok || out_q.size() !== 14) begin failures++; $display("FAIL pad14_beats: got %0d want 14", out_q.size()); end
    for (int i = 0; i < out_q.size(); i++) begin
      checks++; if (pad_q[i] !== (i >= 10)) begin failures++; $display("FAIL pad14_beat%0d: got %b want %b", i, pad_q[i], i >= 10); end
    end
  endtask

  task automatic test_restart();
    bit ok;
    clear_logs();
    configure(32'h0, 26'h1000, 16'h800, 16, 2, 2, 1000);
    pulse_start();
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (req_vld !== 1'b0 || req_pd !== '0) begin failures++; $display("FAIL mid_rst_req: got %b/%h want 0/0", req_vld, req_pd); end
    checks++; if (dat_out_vld !== 1'b0 || dat_out_pd !== '0 || dat_out_pad !== 1'b0) begin failures++; $display("FAIL mid_rst_dat: got %b/%h/%b want 0/0/0", dat_out_vld, dat_out_pd, dat_out_pad); end
    checks++; if (rdma_done !== 1'b0) begin failures++; $display("FAIL mid_rst_done: got %b want 0", rdma_done); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    clear_logs();
    configure(32'h8000, 26'h0, 16'h0, 8, 1, 1, 1000);
    pulse_start();
    wait_done(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL restart_timeout: done seen %0d want 1", done_cnt); end
    checks++; if (cmd_addr_q.size() !== 2) begin failures++; $display("FAIL restart_cmd_count: got %0d want 2", cmd_addr_q.size()); end
    if (cmd_addr_q.size() == 2) begin
      checks++; if (cmd_addr_q[1] !== 32'h8020 || cmd_len_q[1] !== 3) begin failures++; $display("FAIL restart_cmd1: got %h/%0d want 8020/3", cmd_addr_q[1], cmd_len_q[1]); end
    end
    checks++; if (out_q.size() !== 8) begin failures++; $display("FAIL restart_beats: got %0d want 8", out_q.size()); end
    for (int i = 0; i < out_q.size() && i < 8; i++) begin
      checks++; if (out_q[i] !== {32'h8000 + 32'((i / 4) * 32), 32'(i % 4)}) begin failures++; $display("FAIL restart_beat%0d: got %h want %h", i, out_q[i], {32'h8000 + 32'((i / 4) * 32), 32'(i % 4)}); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    req_rdy = 1'b1;
    dat_out_rdy = 1'b1;
    configure(32'h0, 26'h0, 16'h0, 1, 1, 1, 0);
    clear_logs();
    repeat (3) @(negedge clk);
    test_reset();
    test_single();
    test_addr();
    test_backpressure();
    test_pad();
    test_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
